// File: rtl/dcache_req_arb.sv
// Round-robin arbiter that shares one dcache request/response port among NUM_REQ masters.
// It tracks the single outstanding request, routes the response back, and has a watchdog.
module dcache_req_arb #(
    parameter int NUM_REQ     = 2,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_LENGTH = 32,
    parameter int TIMEOUT     = 255,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               rq_valid,
    input  logic [NUM_REQ*ADDR_LENGTH-1:0]   rq_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]     rq_wdata,
    input  logic [NUM_REQ-1:0]               rq_write,
    input  logic [NUM_REQ*3-1:0]             rq_size,
    output logic [NUM_REQ-1:0]               rq_ready,
    output logic [NUM_REQ-1:0]               rs_valid,
    output logic [WORD_SIZE-1:0]             rs_rdata,
    output logic                             c_req_valid,
    output logic [ADDR_LENGTH-1:0]           c_req_addr,
    output logic [WORD_SIZE-1:0]             c_req_wdata,
    output logic                             c_req_write,
    output logic [2:0]                       c_req_size,
    input  logic                             c_req_ready,
    input  logic                             c_resp_valid,
    input  logic [WORD_SIZE-1:0]             c_resp_rdata,
    output logic                             busy,
    output logic [IDX_W-1:0]                 owner,
    output logic                             err_timeout,
    output logic                             err_spurious,
    input  logic                             err_clr
);

    localparam logic [IDX_W:0] NREQ    = (IDX_W+1)'(NUM_REQ);
    localparam logic [15:0]    TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [15:0]      wd_cnt_q, wd_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_spurious_q, err_spurious_d;

    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] rr_next;
    logic             window;
    logic             resp_hit;
    logic             accept;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin : winner_scan
        logic [2*NUM_REQ-1:0] rot;
        logic [IDX_W:0]       sum;
        logic [IDX_W:0]       nxt;
        rot   = {rq_valid, rq_valid} >> rr_ptr_q;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                win   = (sum >= NREQ) ? IDX_W'(sum - NREQ) : IDX_W'(sum);
            end
        end
        nxt     = {1'b0, win} + (IDX_W+1)'(1);
        rr_next = (nxt == NREQ) ? '0 : IDX_W'(nxt);
    end

    assign window   = (state_q == S_IDLE) || ((state_q == S_WAIT) && c_resp_valid);
    assign resp_hit = (state_q == S_WAIT) && c_resp_valid;
    // rst_n gates the request side so nothing leaks out while reset is held.
    assign c_req_valid = rst_n && window && found;
    assign accept      = c_req_valid && c_req_ready;

    always_comb begin : port_mux
        c_req_addr  = '0;
        c_req_wdata = '0;
        c_req_write = 1'b0;
        c_req_size  = '0;
        rq_ready    = '0;
        rs_valid    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (c_req_valid && (win == IDX_W'(k))) begin
                c_req_addr  = rq_addr[k*ADDR_LENGTH +: ADDR_LENGTH];
                c_req_wdata = rq_wdata[k*WORD_SIZE +: WORD_SIZE];
                c_req_write = rq_write[k];
                c_req_size  = rq_size[k*3 +: 3];
                rq_ready[k] = c_req_ready;
            end
            rs_valid[k] = resp_hit && (owner_q == IDX_W'(k));
        end
        rs_rdata = resp_hit ? c_resp_rdata : '0;
    end

    always_comb begin : next_state
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        wd_cnt_d       = wd_cnt_q;
        err_timeout_d  = err_timeout_q & ~err_clr;
        err_spurious_d = err_spurious_q & ~err_clr;
        if ((state_q == S_IDLE) && c_resp_valid) begin
            err_spurious_d = 1'b1;
        end
        if (state_q == S_WAIT) begin
            if (c_resp_valid) begin
                state_d  = S_IDLE;
                owner_d  = '0;
                wd_cnt_d = '0;
            end else if (wd_cnt_q == TO_LAST) begin
                err_timeout_d = 1'b1;
                state_d       = S_IDLE;
                owner_d       = '0;
                wd_cnt_d      = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end
        // A same-cycle accept overrides the release and latches the new owner.
        if (accept) begin
            state_d  = S_WAIT;
            owner_d  = win;
            rr_ptr_d = rr_next;
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            wd_cnt_q       <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            wd_cnt_q       <= wd_cnt_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign busy         = (state_q == S_WAIT);
    assign owner        = owner_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_dcache_req_arb.sv
// Directed bench for dcache_req_arb: a 2-requester instance (TIMEOUT=8) and a 3-requester instance.
module tb_dcache_req_arb;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   n_acc;
    int   n_rs;

    // 2-requester instance
    logic [1:0]  a_rq_valid;
    logic [63:0] a_rq_addr;
    logic [63:0] a_rq_wdata;
    logic [1:0]  a_rq_write;
    logic [5:0]  a_rq_size;
    logic [1:0]  a_rq_ready;
    logic [1:0]  a_rs_valid;
    logic [31:0] a_rs_rdata;
    logic        a_c_req_valid;
    logic [31:0] a_c_req_addr;
    logic [31:0] a_c_req_wdata;
    logic        a_c_req_write;
    logic [2:0]  a_c_req_size;
    logic        a_c_req_ready;
    logic        a_c_resp_valid;
    logic [31:0] a_c_resp_rdata;
    logic        a_busy;
    logic [0:0]  a_owner;
    logic        a_err_timeout;
    logic        a_err_spurious;
    logic        a_err_clr;

    // 3-requester instance
    logic [2:0]  b_rq_valid;
    logic [95:0] b_rq_addr;
    logic [95:0] b_rq_wdata;
    logic [2:0]  b_rq_write;
    logic [8:0]  b_rq_size;
    logic [2:0]  b_rq_ready;
    logic [2:0]  b_rs_valid;
    logic [31:0] b_rs_rdata;
    logic        b_c_req_valid;
    logic [31:0] b_c_req_addr;
    logic [31:0] b_c_req_wdata;
    logic        b_c_req_write;
    logic [2:0]  b_c_req_size;
    logic        b_c_req_ready;
    logic        b_c_resp_valid;
    logic [31:0] b_c_resp_rdata;
    logic        b_busy;
    logic [1:0]  b_owner;
    logic        b_err_timeout;
    logic        b_err_spurious;
    logic        b_err_clr;

    dcache_req_arb #(.NUM_REQ(2), .WORD_SIZE(32), .ADDR_LENGTH(32), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rq_valid(a_rq_valid), .rq_addr(a_rq_addr), .rq_wdata(a_rq_wdata),
        .rq_write(a_rq_write), .rq_size(a_rq_size), .rq_ready(a_rq_ready),
        .rs_valid(a_rs_valid), .rs_rdata(a_rs_rdata),
        .c_req_valid(a_c_req_valid), .c_req_addr(a_c_req_addr), .c_req_wdata(a_c_req_wdata),
        .c_req_write(a_c_req_write), .c_req_size(a_c_req_size), .c_req_ready(a_c_req_ready),
        .c_resp_valid(a_c_resp_valid), .c_resp_rdata(a_c_resp_rdata),
        .busy(a_busy), .owner(a_owner), .err_timeout(a_err_timeout),
        .err_spurious(a_err_spurious), .err_clr(a_err_clr)
    );

    dcache_req_arb #(.NUM_REQ(3), .WORD_SIZE(32), .ADDR_LENGTH(32), .TIMEOUT(255)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rq_valid(b_rq_valid), .rq_addr(b_rq_addr), .rq_wdata(b_rq_wdata),
        .rq_write(b_rq_write), .rq_size(b_rq_size), .rq_ready(b_rq_ready),
        .rs_valid(b_rs_valid), .rs_rdata(b_rs_rdata),
        .c_req_valid(b_c_req_valid), .c_req_addr(b_c_req_addr), .c_req_wdata(b_c_req_wdata),
        .c_req_write(b_c_req_write), .c_req_size(b_c_req_size), .c_req_ready(b_c_req_ready),
        .c_resp_valid(b_c_resp_valid), .c_resp_rdata(b_c_resp_rdata),
        .busy(b_busy), .owner(b_owner), .err_timeout(b_err_timeout),
        .err_spurious(b_err_spurious), .err_clr(b_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_acc = 0; n_rs = 0;
        rst_n = 1'b0;
        a_rq_valid = 2'b01; a_rq_addr = '0; a_rq_wdata = '0; a_rq_write = '0; a_rq_size = '0;
        a_c_req_ready = 1'b1; a_c_resp_valid = 1'b0; a_c_resp_rdata = '0; a_err_clr = 1'b0;
        b_rq_valid = '0; b_rq_addr = {32'hC00, 32'hB00, 32'hA00}; b_rq_wdata = '0;
        b_rq_write = '0; b_rq_size = '0;
        b_c_req_ready = 1'b1; b_c_resp_valid = 1'b0; b_c_resp_rdata = '0; b_err_clr = 1'b0;

        #3;
        chk("rst_busy", a_busy, 0);
        chk("rst_owner", a_owner, 0);
        chk("rst_c_req_valid", a_c_req_valid, 0);
        chk("rst_rq_ready", a_rq_ready, 0);
        chk("rst_rs_valid", a_rs_valid, 0);
        chk("rst_errors", {a_err_timeout, a_err_spurious}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: single read from req0, response after 3 WAIT cycles
        a_rq_addr[31:0] = 32'h100; a_rq_size[2:0] = 3'd2;
        #1;
        chk("t1_rq_ready", a_rq_ready, 2'b01);
        chk("t1_c_req_valid", a_c_req_valid, 1);
        chk("t1_c_req_addr", a_c_req_addr, 32'h100);
        chk("t1_c_req_size", a_c_req_size, 3'd2);
        cyc(); a_rq_valid = 2'b00; #1;
        chk("t1_busy_c1", a_busy, 1);
        chk("t1_c_req_valid_wait", a_c_req_valid, 0);
        chk("t1_rs_idle", a_rs_valid, 0);
        cyc(); #1;
        chk("t1_busy_c2", a_busy, 1);
        cyc(); a_c_resp_valid = 1'b1; a_c_resp_rdata = 32'hDEADBEEF; #1;
        chk("t1_busy_c3", a_busy, 1);
        chk("t1_rs_valid", a_rs_valid, 2'b01);
        chk("t1_rs_rdata", a_rs_rdata, 32'hDEADBEEF);
        cyc(); a_c_resp_valid = 1'b0; #1;
        chk("t1_busy_after", a_busy, 0);
        chk("t1_rs_after", a_rs_valid, 0);

        // T2: both requesters held from reset, grants alternate back-to-back
        rst_n = 1'b0; #2; rst_n = 1'b1;
        a_rq_valid = 2'b11; a_rq_addr = {32'h300, 32'h200};
        a_rq_write = 2'b10; a_rq_wdata = {32'hCAFE0001, 32'h0}; a_rq_size = {3'd2, 3'd2};
        #1;
        chk("t2_grant0", a_rq_ready, 2'b01);
        chk("t2_addr0", a_c_req_addr, 32'h200);
        cyc(); #1;
        chk("t2_owner0", a_owner, 0);
        chk("t2_no_window", a_c_req_valid, 0);
        for (int g = 1; g <= 4; g++) begin
            a_c_resp_valid = 1'b1; a_c_resp_rdata = 32'h1000 + 32'(g);
            if (g == 4) a_rq_valid = 2'b00;
            #1;
            chk("t2_rs_valid", a_rs_valid, ((g % 2) == 1) ? 2'b01 : 2'b10);
            chk("t2_rs_rdata", a_rs_rdata, 32'h1000 + 32'(g));
            chk("t2_rq_ready", a_rq_ready, (g == 4) ? 2'b00 : (((g % 2) == 1) ? 2'b10 : 2'b01));
            if (g == 1) begin
                chk("t2_write1", a_c_req_write, 1);
                chk("t2_wdata1", a_c_req_wdata, 32'hCAFE0001);
            end
            cyc(); a_c_resp_valid = 1'b0; #1;
            chk("t2_busy", a_busy, (g < 4) ? 1 : 0);
            chk("t2_owner", a_owner, (g < 4) ? (g % 2) : 0);
        end

        // T3: req1 issues 4 back-to-back reads, dcache answers every cycle
        a_rq_valid = 2'b10; a_rq_write = 2'b00; a_rq_addr[63:32] = 32'h400;
        #1;
        chk("t3_ready0", a_rq_ready, 2'b10);
        if (a_rq_ready[1]) n_acc++;
        cyc();
        for (int i = 0; i < 4; i++) begin
            a_c_resp_valid = 1'b1; a_c_resp_rdata = 32'h500 + 32'(i);
            if (i == 3) a_rq_valid = 2'b00;
            #1;
            if (a_rq_ready[1]) n_acc++;
            if (a_rs_valid[1]) n_rs++;
            chk("t3_busy", a_busy, 1);
            chk("t3_rs_valid", a_rs_valid, 2'b10);
            cyc();
        end
        a_c_resp_valid = 1'b0; #1;
        chk("t3_accepts", n_acc, 4);
        chk("t3_responses", n_rs, 4);
        chk("t3_busy_end", a_busy, 0);

        // T4: watchdog after 8 silent WAIT cycles, then a late response
        a_rq_valid = 2'b01; #1;
        chk("t4_ready", a_rq_ready, 2'b01);
        cyc(); a_rq_valid = 2'b00;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t4_busy_wait", a_busy, 1);
            chk("t4_no_timeout_yet", a_err_timeout, 0);
            cyc();
        end
        #1;
        chk("t4_busy_released", a_busy, 0);
        chk("t4_err_timeout", a_err_timeout, 1);
        chk("t4_owner", a_owner, 0);
        chk("t4_no_spurious_yet", a_err_spurious, 0);
        a_c_resp_valid = 1'b1; #1;
        chk("t4_late_rs_valid", a_rs_valid, 0);
        cyc(); a_c_resp_valid = 1'b0; #1;
        chk("t4_err_spurious", a_err_spurious, 1);
        a_err_clr = 1'b1;
        cyc(); a_err_clr = 1'b0; #1;
        chk("t4_clr_both", {a_err_timeout, a_err_spurious}, 2'b00);
        a_c_resp_valid = 1'b1; a_err_clr = 1'b1;
        cyc(); a_c_resp_valid = 1'b0; #1;
        chk("t4_set_beats_clr", a_err_spurious, 1);
        cyc(); a_err_clr = 1'b0; #1;
        chk("t4_clr_again", a_err_spurious, 0);

        // T5: asynchronous reset while a request is outstanding
        a_rq_valid = 2'b10;
        cyc(); a_rq_valid = 2'b00; #1;
        chk("t5_busy_before", a_busy, 1);
        chk("t5_owner_before", a_owner, 1);
        rst_n = 1'b0; a_rq_valid = 2'b11; a_c_resp_valid = 1'b1; #1;
        chk("t5_busy", a_busy, 0);
        chk("t5_owner", a_owner, 0);
        chk("t5_rq_ready", a_rq_ready, 0);
        chk("t5_rs_valid", a_rs_valid, 0);
        chk("t5_c_req_valid", a_c_req_valid, 0);
        a_c_resp_valid = 1'b0;
        cyc(); rst_n = 1'b1; #1;
        chk("t5_first_grant", a_rq_ready, 2'b01);
        cyc(); a_rq_valid = 2'b00; a_c_resp_valid = 1'b1; #1;
        chk("t5_rs_req0", a_rs_valid, 2'b01);
        cyc(); a_c_resp_valid = 1'b0;

        // T6: 3 requesters, rr_ptr moved to 2 by granting req1 first
        b_rq_valid = 3'b010; #1;
        chk("t6_grant1", b_rq_ready, 3'b010);
        chk("t6_addr1", b_c_req_addr, 32'hB00);
        cyc(); b_rq_valid = 3'b011; b_c_resp_valid = 1'b1; #1;
        chk("t6_owner1", b_owner, 1);
        chk("t6_rs1", b_rs_valid, 3'b010);
        chk("t6_wrap_grant0", b_rq_ready, 3'b001);
        chk("t6_addr0", b_c_req_addr, 32'hA00);
        cyc(); b_rq_valid = 3'b111; #1;
        chk("t6_owner0", b_owner, 0);
        chk("t6_rs0", b_rs_valid, 3'b001);
        chk("t6_rr_is_1", b_rq_ready, 3'b010);
        cyc(); b_rq_valid = 3'b000; #1;
        chk("t6_owner_last", b_owner, 1);
        chk("t6_rs_last", b_rs_valid, 3'b010);
        cyc(); b_c_resp_valid = 1'b0; #1;
        chk("t6_idle", b_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
